// File: rtl/scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment display slice.
// The code table is indexed by hex nibble and holds active-low {g,f,e,d,c,b,a}.
package scan_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seven_segment.sv
// Combinational hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module seven_segment
  import scan_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_CODES[hex];
  end

endmodule

// File: rtl/scan_display.sv
// Time-multiplexed seven-segment driver with per-frame snapshot of the digit
// values, an anti-ghosting blank at each slot start and per-digit blinking.
module scan_display
  import scan_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("scan_display: NUM_DIGITS must be in 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("scan_display: SCAN_DIV must be >= 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("scan_display: BLINK_DIV must be >= 1");
  end

  logic [SW-1:0]                 scan_cnt;
  logic [IW-1:0]                 idx;
  logic [BW-1:0]                 blink_cnt;
  logic                          phase;
  logic [NUM_DIGITS-1:0][3:0]    snap_digits;
  logic [NUM_DIGITS-1:0]         snap_dp;

  logic                          scan_wrap;
  logic                          frame_wrap;
  logic [3:0]                    cur_hex;
  logic [6:0]                    dec_seg;
  logic [7:0]                    seg_next;
  logic [NUM_DIGITS-1:0]         an_next;

  seven_segment u_seven_segment (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    scan_wrap  = (scan_cnt == SCAN_LAST);
    frame_wrap = scan_wrap && (idx == IDX_LAST);
    cur_hex    = snap_digits[idx];
  end

  // Guard slot and blink only lift the anode; seg keeps the snapshot digit.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = '1;
    if (enable) begin
      seg_next = {~snap_dp[idx], dec_seg};
      if (scan_cnt != '0 && !(blink_en && phase && blink_mask[idx])) begin
        an_next[idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      frame_tick  <= 1'b0;
      seg         <= SEG_BLANK;
      an          <= '1;
    end else begin
      if (scan_wrap) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end

      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        snap_digits <= digits;
        snap_dp     <= dp;
      end

      if (!blink_en) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_scan_display.sv
// Self-checking bench for scan_display: directed scenarios plus random inputs,
// compared every cycle against a cycle-count based reference model.
module tb_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits),
    .dp         (dp),
    .blink_en   (blink_en),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // Model state: edges since reset release, consecutive edges with blink_en
  // high, and the last captured frame.
  int unsigned m_k;
  int unsigned m_b;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;

  logic [6:0] ref_code [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic model_reset();
    m_k   = 0;
    m_b   = 0;
    m_dig = '0;
    m_dp  = '0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int unsigned pos;
    int unsigned dig;
    logic        ph;
    logic [3:0]  nib;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_ft;
    logic [15:0] in_dig;
    logic [3:0]  in_dp;
    logic        in_ben;

    pos    = m_k % SD;
    dig    = (m_k / SD) % ND;
    ph     = ((m_b / BD) % 2) == 1;
    nib    = m_dig[dig*4 +: 4];
    in_dig = digits;
    in_dp  = dp;
    in_ben = blink_en;

    e_seg = enable ? {~m_dp[dig], ref_code[nib]} : 8'hFF;
    e_an  = 4'hF;
    if (enable && pos != 0 && !(blink_en && ph && blink_mask[dig])) e_an[dig] = 1'b0;
    e_ft  = ((m_k + 1) % (SD * ND)) == 0;

    @(posedge clk);
    #1;
    chk("seg", seg, e_seg);
    chk("an", {4'h0, an}, {4'h0, e_an});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});

    if (e_ft) begin
      m_dig = in_dig;
      m_dp  = in_dp;
    end
    m_k++;
    m_b = in_ben ? m_b + 1 : 0;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    digits     = '0;
    dp         = '0;
    blink_en   = 1'b0;
    blink_mask = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_frame_tick", {7'h0, frame_tick}, 8'h00);
    rst = 1'b0;
    model_reset();

    // Two frames of 1234; first frame shows the reset snapshot of zeros.
    enable = 1'b1;
    digits = 16'h1234;
    steps(32);

    // Mid-frame change must wait for the next frame boundary.
    steps(6);
    digits = 16'hABCD;
    steps(26);

    // Blink digit 1, then release and confirm it returns immediately.
    blink_en   = 1'b1;
    blink_mask = 4'b0010;
    steps(64);
    blink_en = 1'b0;
    steps(8);

    // Decimal point on digit 2 only.
    dp = 4'b0100;
    steps(16);

    // Display disabled while the scan keeps running.
    enable = 1'b0;
    steps(20);
    enable = 1'b1;
    steps(12);

    // Random traffic.
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      enable = ($urandom_range(0, 15) != 0);
      step();
    end

    // Asynchronous reset in the middle of a frame.
    enable   = 1'b1;
    blink_en = 1'b0;
    digits   = 16'h5E7F;
    dp       = 4'b1001;
    while ((m_k % (SD * ND)) != 7) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    chk("async_rst_frame_tick", {7'h0, frame_tick}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    steps(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
